// File: rtl/spu_pipe.sv
// spu_pipe: special-purpose execute unit (traps, MFC0/MTC0, ERET, TLB ops, CACHE ops).
// Sits between issue and commit with a DEPTH-entry input FIFO, handshaked
// variable-latency TLB/cache completion and a registered output stage.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   flush                       drop all queued and pending work
//   in_valid/in_ready/issue_inst  issue handshake and instruction payload
//   data_valid/data_vaddr/data_paddr  MMU translate request and result
//   tlb_op/tlb_done             one-hot TLB op pulse and completion
//   cache_op_valid/cache_op/cache_vaddr/cache_paddr/cache_op_ready  cache request
//   cp0_we/cp0_addr/cp0_wdata/cp0_rdata  CP0 access
//   out_ready/spu_to_commit_bus registered commit result with backpressure

package spu_pipe_pkg;
    localparam int unsigned SPU_ROB_W = 4;
    localparam int unsigned PHY_W     = 6;

    typedef logic [31:0] virt_t;
    typedef logic [31:0] phys_t;

    typedef enum logic [2:0] {
        Cache_Code_EMPTY     = 3'd0,
        Cache_Code_ICACHE_II = 3'd1,
        Cache_Code_ICACHE_IST = 3'd2,
        Cache_Code_ICACHE_HI = 3'd3,
        Cache_Code_DCACHE_IWI = 3'd4,
        Cache_Code_DCACHE_IST = 3'd5,
        Cache_Code_DCACHE_HI = 3'd6,
        Cache_Code_DCACHE_HWI = 3'd7
    } CacheCodeType;

    typedef enum logic [3:0] {
        SPU_NOP, SPU_TEQ, SPU_TNE, SPU_TLT, SPU_TLTU, SPU_TGE, SPU_TGEU,
        SPU_MFC0, SPU_MTC0, SPU_ERET,
        SPU_TLBP, SPU_TLBR, SPU_TLBWI, SPU_TLBWR, SPU_CACHE
    } spu_op_t;

    localparam logic [4:0] EXCCODE_TR = 5'h0d;

    typedef struct packed {
        logic       ex;
        logic [4:0] exccode;
    } exception_t;

    typedef struct packed {
        spu_op_t                op;
        logic [31:0]            src1_value;
        logic [31:0]            src2_value;
        logic [15:0]            imm;
        logic                   src2_is_simm;
        logic [7:0]             cp0_addr;
        CacheCodeType           cache_op;
        logic [PHY_W-1:0]       phy_dest;
        logic [SPU_ROB_W-1:0]   rob_entry_num;
    } issue_to_execute_bus_t;

    typedef struct packed {
        logic                   valid;
        logic [SPU_ROB_W-1:0]   rob_entry_num;
        logic [PHY_W-1:0]       phy_dest;
        logic [3:0]             rf_we;
        logic [31:0]            result;
        exception_t             exception;
        logic                   is_store_op;
        logic                   verify_result;
    } execute_to_commit_bus_t;
endpackage

module spu_pipe
    import spu_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned ROB_W = SPU_ROB_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  issue_to_execute_bus_t  issue_inst,
    output logic                   data_valid,
    output virt_t                  data_vaddr,
    input  phys_t                  data_paddr,
    output logic [3:0]             tlb_op,
    input  logic                   tlb_done,
    output logic                   cache_op_valid,
    output CacheCodeType           cache_op,
    output virt_t                  cache_vaddr,
    output phys_t                  cache_paddr,
    input  logic                   cache_op_ready,
    output logic                   cp0_we,
    output logic [7:0]             cp0_addr,
    output logic [31:0]            cp0_wdata,
    input  logic [31:0]            cp0_rdata,
    input  logic                   out_ready,
    output execute_to_commit_bus_t spu_to_commit_bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_XLATE, S_CREQ, S_TWAIT, S_DRAIN} state_t;

    state_t                 state;
    issue_to_execute_bus_t  fifo_mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic                   drain_cache;
    CacheCodeType           cache_op_q;
    execute_to_commit_bus_t out_q;

    issue_to_execute_bus_t  head;
    logic [ROB_W-1:0]       head_rob;
    logic                   non_empty, start, push, pop, load;
    logic                   is_tlb, is_cache, trap_hit;
    logic [31:0]            imm_sext, trap_b, vaddr_calc;
    logic [3:0]             load_rf_we;
    exception_t             load_ex;

    assign head       = fifo_mem[rd_ptr];
    assign head_rob   = ROB_W'(head.rob_entry_num);
    assign non_empty  = (count != '0);
    // Head may only start when the output slot is free, so any completion can load it.
    assign start      = non_empty && (state == S_IDLE) && (!out_q.valid || out_ready) && !flush;
    assign imm_sext   = {{16{head.imm[15]}}, head.imm};
    assign vaddr_calc = head.src1_value + imm_sext;
    assign trap_b     = head.src2_is_simm ? imm_sext : head.src2_value;
    assign is_tlb     = head.op inside {SPU_TLBP, SPU_TLBR, SPU_TLBWI, SPU_TLBWR};
    assign is_cache   = (head.op == SPU_CACHE);

    // Trap condition for the head instruction
    always_comb begin
        trap_hit = 1'b0;
        case (head.op)
            SPU_TEQ:  trap_hit = (head.src1_value == trap_b);
            SPU_TNE:  trap_hit = (head.src1_value != trap_b);
            SPU_TLT:  trap_hit = ($signed(head.src1_value) <  $signed(trap_b));
            SPU_TLTU: trap_hit = (head.src1_value <  trap_b);
            SPU_TGE:  trap_hit = ($signed(head.src1_value) >= $signed(trap_b));
            SPU_TGEU: trap_hit = (head.src1_value >= trap_b);
            default:  trap_hit = 1'b0;
        endcase
    end

    // Per-cycle strobes: pop/load of the head and request pulses
    always_comb begin
        push       = in_valid && in_ready;
        pop        = 1'b0;
        load       = 1'b0;
        load_rf_we = 4'h0;
        load_ex    = '0;
        cp0_we     = 1'b0;
        data_valid = 1'b0;
        tlb_op     = 4'b0000;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_tlb) begin
                        case (head.op)
                            SPU_TLBP:  tlb_op = 4'b0001;
                            SPU_TLBR:  tlb_op = 4'b0010;
                            SPU_TLBWI: tlb_op = 4'b0100;
                            default:   tlb_op = 4'b1000;
                        endcase
                    end else if (is_cache) begin
                        data_valid = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        load = 1'b1;
                        if (head.op == SPU_MFC0) load_rf_we = 4'hF;
                        if (head.op == SPU_MTC0) cp0_we = 1'b1;
                        if (trap_hit) begin
                            load_ex.ex      = 1'b1;
                            load_ex.exccode = EXCCODE_TR;
                        end
                    end
                end
            end
            S_CREQ: begin
                if (!flush && cache_op_ready) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end
            end
            S_TWAIT: begin
                if (!flush && tlb_done) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign in_ready       = (count != CNT_W'(DEPTH)) && !flush && (state != S_DRAIN);
    assign cache_op_valid = (state == S_CREQ) || ((state == S_DRAIN) && drain_cache);
    assign cache_op       = cache_op_valid ? cache_op_q : Cache_Code_EMPTY;
    assign data_vaddr     = data_valid ? vaddr_calc : 32'h0;
    assign cp0_addr       = non_empty ? head.cp0_addr : 8'h0;
    assign cp0_wdata      = non_empty ? head.src2_value : 32'h0;
    assign spu_to_commit_bus = out_q;

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= issue_inst;
    end

    // Pointers, output register and FSM
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            state       <= S_IDLE;
            drain_cache <= 1'b0;
            cache_op_q  <= Cache_Code_EMPTY;
            cache_vaddr <= '0;
            cache_paddr <= '0;
            out_q       <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end

            if (flush) begin
                out_q.valid <= 1'b0;
            end else if (load) begin
                out_q.valid         <= 1'b1;
                out_q.rob_entry_num <= SPU_ROB_W'(head_rob);
                out_q.phy_dest      <= head.phy_dest;
                out_q.rf_we         <= load_rf_we;
                out_q.result        <= cp0_rdata;
                out_q.exception     <= load_ex;
                out_q.is_store_op   <= 1'b0;
                out_q.verify_result <= 1'b0;
            end else if (out_ready) begin
                out_q.valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start && is_tlb)        state <= S_TWAIT;
                    else if (start && is_cache) state <= S_XLATE;
                end
                S_XLATE: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        cache_vaddr <= vaddr_calc;
                        cache_paddr <= data_paddr;
                        cache_op_q  <= head.cache_op;
                        state       <= S_CREQ;
                    end
                end
                S_CREQ: begin
                    // A request accepted in the flush cycle is simply discarded
                    if (cache_op_ready) begin
                        state <= S_IDLE;
                    end else if (flush) begin
                        drain_cache <= 1'b1;
                        state       <= S_DRAIN;
                    end
                end
                S_TWAIT: begin
                    if (tlb_done) begin
                        state <= S_IDLE;
                    end else if (flush) begin
                        drain_cache <= 1'b0;
                        state       <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_cache ? cache_op_ready : tlb_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spu_pipe.sv
// tb_spu_pipe: directed self-checking bench for spu_pipe (DEPTH = 2).
module tb_spu_pipe;
    import spu_pipe_pkg::*;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    issue_to_execute_bus_t  issue_inst;
    logic                   data_valid;
    virt_t                  data_vaddr;
    phys_t                  data_paddr;
    logic [3:0]             tlb_op;
    logic                   tlb_done;
    logic                   cache_op_valid;
    CacheCodeType           cache_op;
    virt_t                  cache_vaddr;
    phys_t                  cache_paddr;
    logic                   cache_op_ready;
    logic                   cp0_we;
    logic [7:0]             cp0_addr;
    logic [31:0]            cp0_wdata;
    logic [31:0]            cp0_rdata;
    logic                   out_ready;
    execute_to_commit_bus_t spu_to_commit_bus;

    int n_vec  = 0;
    int n_miss = 0;
    int n_cp0_we = 0;
    int n_tlb_op = 0;

    spu_pipe #(.DEPTH(2), .ROB_W(4)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .issue_inst(issue_inst),
        .data_valid(data_valid), .data_vaddr(data_vaddr), .data_paddr(data_paddr),
        .tlb_op(tlb_op), .tlb_done(tlb_done),
        .cache_op_valid(cache_op_valid), .cache_op(cache_op),
        .cache_vaddr(cache_vaddr), .cache_paddr(cache_paddr), .cache_op_ready(cache_op_ready),
        .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .out_ready(out_ready), .spu_to_commit_bus(spu_to_commit_bus)
    );

    always #5 clk = ~clk;

    // Count request pulses seen at each active edge
    always @(posedge clk) begin
        if (resetn && cp0_we) n_cp0_we++;
        if (resetn && tlb_op != 4'b0000) n_tlb_op++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic issue_to_execute_bus_t mk(input spu_op_t op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [15:0] imm,
                                                 input logic simm, input CacheCodeType cop,
                                                 input logic [3:0] rob);
        issue_to_execute_bus_t t;
        t.op            = op;
        t.src1_value    = a;
        t.src2_value    = b;
        t.imm           = imm;
        t.src2_is_simm  = simm;
        t.cp0_addr      = 8'h0C;
        t.cache_op      = cop;
        t.phy_dest      = 6'(rob) + 6'd16;
        t.rob_entry_num = rob;
        return t;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Trap table: op, src1, src2, imm, src2_is_simm, expected trap
    spu_op_t     t_op  [5] = '{SPU_TLT, SPU_TLTU, SPU_TGE, SPU_TGEU, SPU_TGEU};
    logic [31:0] t_a   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd5};
    logic [31:0] t_b   [5] = '{32'h8000_0000, 32'd0, 32'd0, 32'd3, 32'd3};
    logic [15:0] t_imm [5] = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic        t_simm[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        t_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int we0;
        int tl0;
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b1;
        issue_inst = mk(SPU_MTC0, 32'h0, 32'h55, 16'h0, 1'b0, Cache_Code_EMPTY, 4'd0);
        data_paddr = '0; tlb_done = 1'b0; cache_op_ready = 1'b0;
        cp0_rdata = 32'h0; out_ready = 1'b0;

        // Reset held two cycles with in_valid high
        repeat (2) @(posedge clk);
        cyc();
        check("rst_out_valid", 64'(spu_to_commit_bus.valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_cache_op", 64'(cache_op), 64'(Cache_Code_EMPTY));
        check("rst_tlb_op", 64'(tlb_op), 64'd0);
        check("rst_cp0_we", 64'(cp0_we), 64'd0);
        resetn = 1'b1; in_valid = 1'b0;
        cyc();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_cache_valid", 64'(cache_op_valid), 64'd0);
        check("post_rst_data_valid", 64'(data_valid), 64'd0);

        // Back-to-back TEQ, TNE, MFC0 with out_ready high
        out_ready = 1'b1; cp0_rdata = 32'hDEAD_BEEF;
        in_valid = 1'b1; issue_inst = mk(SPU_TEQ, 32'd5, 32'd5, 16'h0, 1'b0, Cache_Code_EMPTY, 4'd1);
        cyc();
        check("s_lat_not_yet", 64'(spu_to_commit_bus.valid), 64'd0);
        issue_inst = mk(SPU_TNE, 32'd5, 32'd5, 16'h0, 1'b0, Cache_Code_EMPTY, 4'd2);
        cyc();
        check("teq_valid", 64'(spu_to_commit_bus.valid), 64'd1);
        check("teq_ex", 64'(spu_to_commit_bus.exception), 64'({1'b1, EXCCODE_TR}));
        check("teq_rob", 64'(spu_to_commit_bus.rob_entry_num), 64'd1);
        issue_inst = mk(SPU_MFC0, 32'd0, 32'd0, 16'h0, 1'b0, Cache_Code_EMPTY, 4'd3);
        cyc();
        in_valid = 1'b0;
        check("tne_valid", 64'(spu_to_commit_bus.valid), 64'd1);
        check("tne_ex", 64'(spu_to_commit_bus.exception.ex), 64'd0);
        check("tne_rob", 64'(spu_to_commit_bus.rob_entry_num), 64'd2);
        cyc();
        check("mfc0_valid", 64'(spu_to_commit_bus.valid), 64'd1);
        check("mfc0_result", 64'(spu_to_commit_bus.result), 64'hDEAD_BEEF);
        check("mfc0_rf_we", 64'(spu_to_commit_bus.rf_we), 64'hF);
        check("mfc0_phy", 64'(spu_to_commit_bus.phy_dest), 64'd19);
        check("mfc0_store", 64'({spu_to_commit_bus.is_store_op, spu_to_commit_bus.verify_result}), 64'd0);
        cyc();
        check("stream_drained", 64'(spu_to_commit_bus.valid), 64'd0);

        // Trap comparisons, signed/unsigned and immediate selection
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            issue_inst = mk(t_op[i], t_a[i], t_b[i], t_imm[i], t_simm[i], Cache_Code_EMPTY, 4'(i + 8));
            cyc();
            in_valid = 1'b0;
            cyc();
            check($sformatf("trap%0d_ex", i), 64'(spu_to_commit_bus.exception.ex), 64'(t_exp[i]));
            check($sformatf("trap%0d_rf_we", i), 64'(spu_to_commit_bus.rf_we), 64'd0);
        end
        cyc();

        // Backpressure: three MTC0 with out_ready low
        out_ready = 1'b0; we0 = n_cp0_we;
        in_valid = 1'b1; issue_inst = mk(SPU_MTC0, 32'd0, 32'hA1, 16'h0, 1'b0, Cache_Code_EMPTY, 4'd4);
        cyc();
        check("bp_ready_1", 64'(in_ready), 64'd1);
        issue_inst = mk(SPU_MTC0, 32'd0, 32'hA2, 16'h0, 1'b0, Cache_Code_EMPTY, 4'd5);
        cyc();
        check("bp_ready_2", 64'(in_ready), 64'd1);
        issue_inst = mk(SPU_MTC0, 32'd0, 32'hA3, 16'h0, 1'b0, Cache_Code_EMPTY, 4'd6);
        cyc();
        check("bp_full", 64'(in_ready), 64'd0);
        issue_inst = mk(SPU_MTC0, 32'd0, 32'hA4, 16'h0, 1'b0, Cache_Code_EMPTY, 4'd7);
        cyc();
        in_valid = 1'b0;
        check("bp_still_full", 64'(in_ready), 64'd0);
        check("bp_hold_rob", 64'(spu_to_commit_bus.rob_entry_num), 64'd4);
        check("bp_one_we", 64'(n_cp0_we - we0), 64'd1);
        out_ready = 1'b1;
        repeat (5) cyc();
        check("bp_three_we", 64'(n_cp0_we - we0), 64'd3);
        check("bp_idle", 64'(spu_to_commit_bus.valid), 64'd0);

        // CACHE: translate, hold request 4 cycles, commit after acceptance
        in_valid = 1'b1;
        issue_inst = mk(SPU_CACHE, 32'h1000, 32'h0, 16'hFFFC, 1'b0, Cache_Code_DCACHE_HWI, 4'd9);
        cyc();
        in_valid = 1'b0;
        check("c_data_valid", 64'(data_valid), 64'd1);
        check("c_vaddr", 64'(data_vaddr), 64'h0FFC);
        cyc();
        data_paddr = 32'h0002_0FFC;
        check("c_xlate_no_req", 64'(cache_op_valid), 64'd0);
        check("c_xlate_dv_low", 64'(data_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            data_paddr = 32'h0;
            if (k == 3) cache_op_ready = 1'b1;
            check($sformatf("c_req_valid%0d", k), 64'(cache_op_valid), 64'd1);
            check($sformatf("c_req_op%0d", k), 64'(cache_op), 64'(Cache_Code_DCACHE_HWI));
            check($sformatf("c_req_nout%0d", k), 64'(spu_to_commit_bus.valid), 64'd0);
        end
        check("c_cvaddr", 64'(cache_vaddr), 64'h0FFC);
        check("c_cpaddr", 64'(cache_paddr), 64'h0002_0FFC);
        cyc();
        cache_op_ready = 1'b0;
        check("c_out_valid", 64'(spu_to_commit_bus.valid), 64'd1);
        check("c_out_rob", 64'(spu_to_commit_bus.rob_entry_num), 64'd9);
        check("c_out_rf_we", 64'(spu_to_commit_bus.rf_we), 64'd0);
        check("c_req_dropped", 64'(cache_op), 64'(Cache_Code_EMPTY));
        cyc();
        check("c_out_clear", 64'(spu_to_commit_bus.valid), 64'd0);

        // tlb_done outside TWAIT has no effect
        tlb_done = 1'b1;
        cyc();
        tlb_done = 1'b0;
        cyc();
        check("tlb_stray_done", 64'(spu_to_commit_bus.valid), 64'd0);

        // TLBWI: one-cycle op pulse, done after 3 cycles
        tl0 = n_tlb_op;
        in_valid = 1'b1;
        issue_inst = mk(SPU_TLBWI, 32'h0, 32'h0, 16'h0, 1'b0, Cache_Code_EMPTY, 4'd10);
        cyc();
        in_valid = 1'b0;
        check("tlb_op_pulse", 64'(tlb_op), 64'b0100);
        cyc();
        check("tlb_op_low", 64'(tlb_op), 64'd0);
        cyc();
        cyc();
        tlb_done = 1'b1;
        check("tlb_wait_nout", 64'(spu_to_commit_bus.valid), 64'd0);
        cyc();
        tlb_done = 1'b0;
        check("tlb_out_valid", 64'(spu_to_commit_bus.valid), 64'd1);
        check("tlb_out_rf_we", 64'(spu_to_commit_bus.rf_we), 64'd0);
        check("tlb_out_rob", 64'(spu_to_commit_bus.rob_entry_num), 64'd10);
        check("tlb_one_pulse", 64'(n_tlb_op - tl0), 64'd1);
        cyc();

        // Flush in CREQ with an MTC0 queued behind
        we0 = n_cp0_we;
        in_valid = 1'b1;
        issue_inst = mk(SPU_CACHE, 32'h2000, 32'h0, 16'h0010, 1'b0, Cache_Code_ICACHE_HI, 4'd11);
        cyc();
        issue_inst = mk(SPU_MTC0, 32'h0, 32'hBB, 16'h0, 1'b0, Cache_Code_EMPTY, 4'd12);
        cyc();
        in_valid = 1'b0;
        cyc();
        flush = 1'b1;
        check("f_creq", 64'(cache_op_valid), 64'd1);
        check("f_in_ready_flush", 64'(in_ready), 64'd0);
        cyc();
        flush = 1'b0;
        check("f_drain_held", 64'(cache_op_valid), 64'd1);
        check("f_drain_op", 64'(cache_op), 64'(Cache_Code_ICACHE_HI));
        check("f_drain_in_ready", 64'(in_ready), 64'd0);
        check("f_no_out", 64'(spu_to_commit_bus.valid), 64'd0);
        cyc();
        cache_op_ready = 1'b1;
        check("f_drain_held2", 64'(cache_op_valid), 64'd1);
        cyc();
        cache_op_ready = 1'b0;
        check("f_done_no_out", 64'(spu_to_commit_bus.valid), 64'd0);
        check("f_done_no_req", 64'(cache_op_valid), 64'd0);
        check("f_in_ready", 64'(in_ready), 64'd1);
        repeat (3) cyc();
        check("f_fifo_dropped", 64'(n_cp0_we - we0), 64'd0);
        check("f_still_no_out", 64'(spu_to_commit_bus.valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
